// File: rtl/router_fsm_if.sv
// Handshake and status bundle between the 1x3 router source/FIFOs/register block
// and the router control FSM.
interface router_fsm_if;
  logic       packet_valid;
  logic [1:0] datain;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  modport master (
    output packet_valid, datain, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state,
    input  full_state, rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  packet_valid, datain, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state,
    output full_state, rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: sequences header/payload/parity loading into
// router_reg, generates the FIFO write strobe and source back-pressure.
//
//   state              | meaning
//   DECODE_ADDRESS     | idle, waiting for a header with a valid address
//   LOAD_FIRST_DATA    | header byte loaded into the register block
//   LOAD_DATA          | payload bytes written to the FIFO
//   LOAD_PARITY        | parity byte written to the FIFO
//   FIFO_FULL_STATE    | destination FIFO full, writes paused
//   LOAD_AFTER_FULL    | flush the byte held while the FIFO was full
//   WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
//   CHECK_PARITY_ERROR | parity compare, internal registers cleared
module router_fsm (
  input  logic         clk,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       addr_ok;
  logic       in_empty;
  logic       sel_empty;
  logic       sel_srst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // FIFO status muxes: one keyed by the incoming header, one by the latched port
  always_comb begin
    in_empty  = 1'b0;
    sel_empty = 1'b0;
    sel_srst  = 1'b0;
    case (bus.datain)
      2'd0:    in_empty = bus.fifo_empty_0;
      2'd1:    in_empty = bus.fifo_empty_1;
      2'd2:    in_empty = bus.fifo_empty_2;
      default: in_empty = 1'b0;
    endcase
    case (addr_q)
      2'd0: begin
        sel_empty = bus.fifo_empty_0;
        sel_srst  = bus.soft_reset_0;
      end
      2'd1: begin
        sel_empty = bus.fifo_empty_1;
        sel_srst  = bus.soft_reset_1;
      end
      2'd2: begin
        sel_empty = bus.fifo_empty_2;
        sel_srst  = bus.soft_reset_2;
      end
      default: begin
        sel_empty = 1'b0;
        sel_srst  = 1'b0;
      end
    endcase
  end

  assign addr_ok = (bus.datain != 2'd3);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && bus.packet_valid && addr_ok) begin
      addr_d = bus.datain;
    end
    case (state_q)
      DECODE_ADDRESS: begin
        if (bus.packet_valid && addr_ok) begin
          state_d = in_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)          state_d = FIFO_FULL_STATE;
        else if (!bus.packet_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)           state_d = DECODE_ADDRESS;
        else if (bus.low_packet_valid) state_d = LOAD_PARITY;
        else                           state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // Read-timeout soft reset of the active port aborts the packet from anywhere
    if (sel_srst) state_d = DECODE_ADDRESS;
  end

  assign bus.detect_add    = (state_q == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_q == LOAD_DATA);
  assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
  assign bus.full_state    = (state_q == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                             (state_q == LOAD_AFTER_FULL);
  assign bus.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: table of per-edge stimulus with expected
// decoded outputs, scored through a queue, plus an asynchronous-reset sequence.
module tb_router_fsm;

  // Output vector order: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0010;
  localparam logic [7:0] O_LAF = 8'b0001_0011;
  localparam logic [7:0] O_FUL = 8'b0000_1001;
  localparam logic [7:0] O_CPE = 8'b0000_0101;
  localparam logic [7:0] O_LP  = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  typedef struct {
    string      name;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pdone;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic resetn;
  router_fsm_if bus ();

  router_fsm dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] act;
  assign act = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

  int n_checks = 0;
  int n_fail   = 0;

  vec_t       vecs[$];
  logic [7:0] sb_exp[$];
  string      sb_name[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs actual=%b required=%b", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic pv, input logic [1:0] din,
                     input logic full, input logic [2:0] empty, input logic [2:0] srst,
                     input logic pdone, input logic lpv, input logic [7:0] exp);
    vec_t v;
    v.name = name; v.pv = pv; v.din = din; v.full = full; v.empty = empty;
    v.srst = srst; v.pdone = pdone; v.lpv = lpv; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.packet_valid     = v.pv;
    bus.datain           = v.din;
    bus.fifo_full        = v.full;
    bus.fifo_empty_0     = v.empty[0];
    bus.fifo_empty_1     = v.empty[1];
    bus.fifo_empty_2     = v.empty[2];
    bus.soft_reset_0     = v.srst[0];
    bus.soft_reset_1     = v.srst[1];
    bus.soft_reset_2     = v.srst[2];
    bus.parity_done      = v.pdone;
    bus.low_packet_valid = v.lpv;
  endtask

  // Drive one vector, score the decoded outputs just after the next rising edge
  task automatic step(input vec_t v);
    logic [7:0] e;
    string      n;
    drive(v);
    sb_exp.push_back(v.exp);
    sb_name.push_back(v.name);
    @(posedge clk);
    #1;
    if (sb_exp.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: actual=empty required=entry");
    end else begin
      e = sb_exp.pop_front();
      n = sb_name.pop_front();
      check(n, act, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    idle.name = "idle"; idle.pv = 0; idle.din = 0; idle.full = 0; idle.empty = 3'b111;
    idle.srst = 0; idle.pdone = 0; idle.lpv = 0; idle.exp = O_DA;

    // Invalid address dropped
    add("inv_addr_a", 1, 2'd3, 0, 3'b111, 0, 0, 0, O_DA);
    add("inv_addr_b", 1, 2'd3, 0, 3'b111, 0, 0, 0, O_DA);
    // Normal packet to port 1, 14 payload bytes
    add("norm_lfd", 1, 2'd1, 0, 3'b111, 0, 0, 0, O_LFD);
    for (int i = 0; i < 14; i++) add($sformatf("norm_ld_%0d", i), 1, 2'd1, 0, 3'b111, 0, 0, 0, O_LD);
    add("norm_lp",  0, 2'd0, 0, 3'b111, 0, 0, 0, O_LP);
    add("norm_cpe", 0, 2'd0, 0, 3'b111, 0, 0, 0, O_CPE);
    add("norm_da",  0, 2'd0, 0, 3'b111, 0, 0, 0, O_DA);
    // Busy destination port 2; datain/empty_0 changes must not disturb the latched port
    add("wte_enter", 1, 2'd2, 0, 3'b011, 0, 0, 0, O_WTE);
    for (int i = 0; i < 4; i++) add($sformatf("wte_hold_%0d", i), 1, 2'd0, 0, 3'b011, 0, 0, 0, O_WTE);
    add("wte_lfd", 1, 2'd0, 0, 3'b111, 0, 0, 0, O_LFD);
    add("wte_ld",  1, 2'd0, 0, 3'b111, 0, 0, 0, O_LD);
    // Full stall, then each LOAD_AFTER_FULL branch
    for (int i = 0; i < 3; i++) add($sformatf("full_%0d", i), 1, 2'd0, 1, 3'b111, 0, 0, 0, O_FUL);
    add("laf_a",       1, 2'd0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("laf_to_ld",   1, 2'd0, 0, 3'b111, 0, 0, 0, O_LD);
    add("full_b",      1, 2'd0, 1, 3'b111, 0, 0, 0, O_FUL);
    add("laf_b",       1, 2'd0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("laf_to_lp",   0, 2'd0, 0, 3'b111, 0, 0, 1, O_LP);
    add("lp_to_cpe",   0, 2'd0, 1, 3'b111, 0, 0, 0, O_CPE);
    add("cpe_to_full", 0, 2'd0, 1, 3'b111, 0, 0, 0, O_FUL);
    add("laf_c",       0, 2'd0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("laf_to_da",   0, 2'd0, 0, 3'b111, 0, 1, 0, O_DA);
    // Packet to port 0: simultaneous full/valid-drop, then soft resets
    add("p0_lfd",     1, 2'd0, 0, 3'b111, 0, 0, 0, O_LFD);
    add("p0_ld",      1, 2'd0, 0, 3'b111, 0, 0, 0, O_LD);
    add("simul_full", 0, 2'd0, 1, 3'b111, 0, 0, 0, O_FUL);
    add("p0_laf",     1, 2'd0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("p0_ld2",     1, 2'd0, 0, 3'b111, 0, 0, 0, O_LD);
    add("srst1_ign",  1, 2'd0, 0, 3'b111, 3'b010, 0, 0, O_LD);
    add("srst2_ign",  1, 2'd0, 0, 3'b111, 3'b100, 0, 0, O_LD);
    add("srst0_abrt", 1, 2'd0, 0, 3'b111, 3'b001, 0, 0, O_DA);
    add("srst0_prio", 1, 2'd0, 0, 3'b111, 3'b001, 0, 0, O_DA);
    add("post_srst",  0, 2'd0, 0, 3'b111, 0, 0, 0, O_DA);

    drive(idle);
    resetn = 1'b0;
    #12;
    check("reset_state", act, O_DA);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i]);

    // Asynchronous reset in LOAD_DATA takes effect without a clock edge
    begin
      vec_t v;
      v = idle; v.pv = 1; v.din = 2'd1; v.name = "ar_lfd"; v.exp = O_LFD; step(v);
      v.name = "ar_ld"; v.exp = O_LD; step(v);
      #3;
      resetn = 1'b0;
      #1;
      check("async_reset_now", act, O_DA);
      #2;
      resetn = 1'b1;
      v = idle; v.name = "after_reset_idle"; step(v);
      step(v);
    end

    if (sb_exp.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: actual=%0d required=0", sb_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control state machine of the 1x3 router.
- Sits directly upstream of router_reg: generates detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg, which drive router_reg's header/payload/parity loading.
- Also drives write_enb_reg (FIFO write strobe, via synchronizer) and busy (source back-pressure).
- Consumes packet_valid and header address bits from the source, FIFO status, and parity_done/low_packet_valid from router_reg.

Parameters:
None. Three output ports fixed; 2-bit address.

Ports:
clk  input  1  system clock, all state changes on rising edge
resetn  input  1  asynchronous active-low reset
packet_valid  input  1  source asserts for header and payload bytes, deasserts on parity byte
datain  input  2  header address bits datain[1:0]; 0,1,2 valid, 3 invalid
fifo_full  input  1  selected FIFO full
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_reset_0  input  1  read-timeout soft reset of FIFO 0
soft_reset_1  input  1  read-timeout soft reset of FIFO 1
soft_reset_2  input  1  read-timeout soft reset of FIFO 2
parity_done  input  1  from router_reg: parity byte captured
low_packet_valid  input  1  from router_reg: packet_valid fell while FIFO full
detect_add  output  1  state == DECODE_ADDRESS
lfd_state  output  1  state == LOAD_FIRST_DATA
ld_state  output  1  state == LOAD_DATA
laf_state  output  1  state == LOAD_AFTER_FULL
full_state  output  1  state == FIFO_FULL_STATE
rst_int_reg  output  1  state == CHECK_PARITY_ERROR
write_enb_reg  output  1  FIFO write enable
busy  output  1  source must hold current byte

Behaviour:
- Reset: resetn low forces state to DECODE_ADDRESS and latched address to 0 immediately, without waiting for clk.
  - Output values during reset: detect_add=1; all other state outputs 0; write_enb_reg=0; busy=0.
- All outputs are Moore outputs, decoded from the registered state only.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Address latch:
  - Captures datain in DECODE_ADDRESS on the edge where packet_valid=1 and datain!=3.
  - Not updated otherwise.
  - fifo_empty_x and soft_reset_x are selected by the latched address.
- Transitions, evaluated at each rising edge:
  - DECODE_ADDRESS:
    - packet_valid & datain!=3 & fifo_empty[datain] -> LOAD_FIRST_DATA.
    - packet_valid & datain!=3 & !fifo_empty[datain] -> WAIT_TILL_EMPTY.
    - Otherwise (including datain==3) stay. An invalid-address packet is dropped.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditionally. One-cycle header load.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else !packet_valid -> LOAD_PARITY.
    - else stay.
    - fifo_full takes priority over packet_valid falling.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_packet_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR, unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[latched] -> LOAD_FIRST_DATA, else stay.
- Soft reset:
  - soft_reset[latched]=1 forces DECODE_ADDRESS on the next edge from any state.
  - Highest priority among synchronous conditions.
  - Soft resets of non-latched ports are ignored.
- State encoding: implementer's choice, 3-bit binary or one-hot. Unreachable encodings recover to DECODE_ADDRESS on the next edge.
- Minimum packet of N payload bytes, no FIFO stall, from first DECODE_ADDRESS transition:
  - 1 LOAD_FIRST_DATA cycle.
  - N LOAD_DATA cycles.
  - 1 LOAD_PARITY cycle.
  - 1 CHECK_PARITY_ERROR cycle.
  - Then back in DECODE_ADDRESS.

Test Plan:
- Reset: resetn=0 mid-cycle, while in LOAD_DATA -> immediately detect_add=1, busy=0, write_enb_reg=0; remains in DECODE_ADDRESS after release with packet_valid=0.
- Normal packet: addr=1, fifo_empty_1=1, payload 14 bytes, packet_valid drops after 15 valid cycles -> lfd_state 1 cycle, ld_state 14 cycles, then LOAD_PARITY with write_enb_reg=1 busy=1, then rst_int_reg 1 cycle, then detect_add=1.
- Busy destination: addr=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY with busy=1 for 5 cycles; fifo_empty_2=1 -> lfd_state next cycle.
- Full stall: fifo_full=1 during LOAD_DATA for 3 cycles -> full_state=1, busy=1, write_enb_reg=0 for 3 cycles, then laf_state 1 cycle.
  - Branch parity_done=0, low_packet_valid=0 -> LOAD_DATA.
  - Branch low_packet_valid=1 -> LOAD_PARITY.
  - Branch parity_done=1 -> DECODE_ADDRESS.
- Invalid address and soft reset:
  - datain=3 with packet_valid=1 -> stays DECODE_ADDRESS, no write_enb_reg.
  - Packet to addr 0 in LOAD_DATA, soft_reset_1=1 -> no effect.
  - soft_reset_0=1 -> detect_add=1 next cycle.
- Simultaneous events in LOAD_DATA: fifo_full=1 and packet_valid=0 same edge -> FIFO_FULL_STATE, not LOAD_PARITY.
